// File: rtl/barrel_shift_arb_if.sv
// Handshake bundle between two shift requesters, the shared shifter and the result consumer.
interface barrel_shift_arb_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic [AW-1:0]    req0_amt;
  logic             req0_dir;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic [AW-1:0]    req1_amt;
  logic             req1_dir;
  logic             req1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    input  req0_ready,
    output req1_valid, req1_data, req1_amt, req1_dir,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  // Arbiter / shifter side
  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    output req0_ready,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );
endinterface

// File: rtl/barrel_shift_arb.sv
// Two-requester round-robin arbiter sharing one logical barrel shifter,
// with a single-entry registered result stage (EMPTY/FULL).
module barrel_shift_arb #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  barrel_shift_arb_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept_c;
  logic             grant0_c, grant1_c;
  logic             ready0_c, ready1_c;
  logic             xfer_c;
  logic [WIDTH-1:0] op_data_c;
  logic [AW-1:0]    op_amt_c;
  logic             op_dir_c;
  logic [WIDTH-1:0] shifted_c;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    can_accept_c = (state_q == EMPTY) || bus.out_ready;
    grant0_c     = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1_c     = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    ready0_c     = grant0_c && can_accept_c && !rst;
    ready1_c     = grant1_c && can_accept_c && !rst;
    xfer_c       = ready0_c || ready1_c;
  end

  // Shared shifter: operand muxed from the granted requester, zero fill both ways.
  always_comb begin
    op_data_c = grant1_c ? bus.req1_data : bus.req0_data;
    op_amt_c  = grant1_c ? bus.req1_amt  : bus.req0_amt;
    op_dir_c  = grant1_c ? bus.req1_dir  : bus.req0_dir;
    shifted_c = op_dir_c ? (op_data_c << op_amt_c) : (op_data_c >> op_amt_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      EMPTY: if (xfer_c) state_d = FULL;
      FULL: begin
        if (xfer_c)             state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer_c) begin
      out_data_d   = shifted_c;
      out_id_d     = ready1_c;
      last_grant_d = ready1_c;
    end
  end

  always_comb begin
    bus.out_valid  = (state_q == FULL);
    bus.out_data   = out_data_q;
    bus.out_id     = out_id_q;
    bus.req0_ready = ready0_c;
    bus.req1_ready = ready1_c;
  end

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Directed bench for barrel_shift_arb (WIDTH=8): readies checked inline,
// results checked against a queue of expected {id,data} pushed at acceptance.
module tb_barrel_shift_arb;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  barrel_shift_arb_if #(.WIDTH(8)) bus ();

  barrel_shift_arb #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drv0(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dir);
    bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_dir = dir;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dir);
    bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_dir = dir;
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(r1));
  endtask

  // Consume expected results whenever the DUT hands one off.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(bus.out_data), 32'(e[7:0]));
        chk("sb_id", 32'(bus.out_id), 32'(e[8]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drv0(1'b1, 8'h81, 3'd1, 1'b1);
    drv1(1'b1, 8'h81, 3'd7, 1'b0);

    // Reset: readies low even with both valid
    at_neg();
    chk_rdy("in_reset", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);

    // Tie after reset: req0 first, then req1
    at_neg();
    chk_rdy("tie_c1", 1'b1, 1'b0);
    sb.push_back({1'b0, 8'h02});
    tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk_rdy("tie_c2", 1'b0, 1'b1);
    chk("tie_c2_valid", 32'(bus.out_valid), 32'd1);
    sb.push_back({1'b1, 8'h01});
    tick();
    drv1(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk("tie_c3_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Sustained contention: alternate 0,1,0,1,0,1 with back-to-back results
    drv0(1'b1, 8'h3C, 3'd2, 1'b1);
    drv1(1'b1, 8'h3C, 3'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk_rdy("contend", (i % 2) == 0, (i % 2) == 1);
      if (i > 0) chk("contend_valid", 32'(bus.out_valid), 32'd1);
      sb.push_back(((i % 2) == 0) ? {1'b0, 8'hF0} : {1'b1, 8'h0F});
      tick();
    end
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    drv1(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk("contend_last_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Single right shift, then drain to EMPTY
    drv0(1'b1, 8'hB4, 3'd3, 1'b0);
    at_neg();
    chk_rdy("single", 1'b1, 1'b0);
    sb.push_back({1'b0, 8'h16});
    tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    tick();
    at_neg();
    chk("single_empty", 32'(bus.out_valid), 32'd0);
    tick();

    // Boundary shift amounts, back to back
    drv0(1'b1, 8'h5A, 3'd0, 1'b0);
    at_neg(); chk_rdy("amt0", 1'b1, 1'b0); sb.push_back({1'b0, 8'h5A}); tick();
    drv0(1'b1, 8'hFF, 3'd7, 1'b1);
    at_neg(); chk_rdy("amt7_left", 1'b1, 1'b0); sb.push_back({1'b0, 8'h80}); tick();
    drv0(1'b1, 8'hFF, 3'd7, 1'b0);
    at_neg(); chk_rdy("amt7_right", 1'b1, 1'b0); sb.push_back({1'b0, 8'h01}); tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    tick();

    // Backpressure: hold F0 for 3 cycles, then consume and accept req1 together
    drv0(1'b1, 8'h3C, 3'd2, 1'b1);
    at_neg(); chk_rdy("bp_load", 1'b1, 1'b0); sb.push_back({1'b0, 8'hF0}); tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    drv1(1'b1, 8'h81, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'hF0);
      chk("bp_hold_id", 32'(bus.out_id), 32'd0);
      chk_rdy("bp_hold", 1'b0, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    at_neg();
    chk_rdy("bp_release", 1'b0, 1'b1);
    sb.push_back({1'b1, 8'h81});
    tick();
    drv1(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk("bp_after_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Reset while FULL and stalled: result discarded, priority restored to req0
    drv0(1'b1, 8'h5A, 3'd1, 1'b0);
    at_neg(); chk_rdy("mid_load", 1'b1, 1'b0); tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    at_neg();
    chk("mid_full_data", 32'(bus.out_data), 32'h2D);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drv0(1'b1, 8'h81, 3'd1, 1'b1);
    drv1(1'b1, 8'h81, 3'd7, 1'b0);
    at_neg();
    chk_rdy("mid_in_reset", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_id", 32'(bus.out_id), 32'd0);
    at_neg();
    chk_rdy("mid_tie", 1'b1, 1'b0);
    sb.push_back({1'b0, 8'h02});
    tick();
    drv0(1'b0, 8'h00, 3'd0, 1'b0);
    drv1(1'b0, 8'h00, 3'd0, 1'b0);
    at_neg();
    chk("mid_tie_valid", 32'(bus.out_valid), 32'd1);
    tick();
    at_neg();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_shift_arb.md
BARREL_SHIFT_ARB -- requirements
Module: barrel_shift_arb

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; SHALL be a power of two, at least 2.
REQ-002 Derived width: AW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-006 req0_data  input  WIDTH  requester 0 operand.
REQ-007 req0_amt  input  AW  requester 0 shift amount, range 0..WIDTH-1.
REQ-008 req0_dir  input  1  requester 0 direction: 0 = logical right, 1 = logical left.
REQ-009 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-010 req1_valid, req1_data, req1_amt, req1_dir, req1_ready: same widths and meanings as REQ-005..REQ-009, for requester 1.
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_id  output  1  requester that owns the result (0 or 1).
REQ-014 out_ready  input  1  downstream consumer accepts the result.

Function
REQ-015 The block SHALL time-share one combinational shift datapath between the two requesters. The datapath SHALL be a logical shift with zero fill in both directions.
REQ-016 The output stage SHALL be a two-state FSM, EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-017 Output-side handshake signal: can_accept = !out_valid || out_ready.
REQ-018 Grant, when exactly one requester is valid: that requester.
REQ-019 Grant, when both requesters are valid: the requester not recorded in last_grant (round-robin).
REQ-020 Grant, when neither requester is valid: none.
REQ-021 reqN_ready SHALL equal grantN && can_accept, combinationally.
REQ-022 reqN_ready SHALL never be asserted while reqN_valid = 0.
REQ-023 At most one reqN_ready SHALL be high in any cycle.
REQ-024 A transfer occurs on a cycle where reqN_valid && reqN_ready.
REQ-025 On a transfer, the next edge SHALL load:
- out_data = shifted reqN_data;
- out_id = N;
- out_valid = 1;
- last_grant = N.
REQ-026 Latency: exactly 1 cycle from transfer to out_valid.
REQ-027 Throughput: 1 operation per cycle while out_ready = 1.
REQ-028 FULL -> EMPTY when out_ready = 1 and no transfer occurs in that cycle.
REQ-029 FULL -> FULL with new contents when out_ready = 1 and a transfer occurs in the same cycle.
REQ-030 EMPTY -> FULL on a transfer.
REQ-031 While FULL and out_ready = 0: out_data and out_id SHALL hold stable, and both reqN_ready SHALL be 0.
REQ-032 last_grant SHALL update only on a transfer; a requester that is waiting keeps priority until it is served.
REQ-033 Shift amount 0 SHALL pass the operand through unchanged.
REQ-034 Shift amount WIDTH-1 SHALL leave a single surviving bit at most.
REQ-035 No rotation or wrap-around SHALL occur.
REQ-036 Requesters SHALL hold data, amt and dir stable while valid is high and not yet accepted; the block does not latch unaccepted requests.

Reset
REQ-037 While rst = 1 at a rising edge, the next state SHALL be: out_valid = 0, out_data = 0, out_id = 0, last_grant = 1 (so requester 0 wins the first tie).
REQ-038 While rst = 1, req0_ready and req1_ready SHALL be 0 regardless of inputs.
REQ-039 Reset asserted while FULL SHALL discard the held result without a handshake.
REQ-040 After rst deasserts, the first transfer SHALL be possible in the same cycle.

Verification (WIDTH=8)
REQ-041 Single right shift: req0 valid, data 8'hB4, amt 3, dir 0, out_ready 1 -> req0_ready 1; next cycle out_valid 1, out_data 8'h16, out_id 0.
REQ-042 Tie after reset: both valid; req0 = 8'h81 amt 1 dir 1; req1 = 8'h81 amt 7 dir 0; out_ready 1 -> cycle 1 grants req0 (out 8'h02, id 0); cycle 2 grants req1 (out 8'h01, id 1).
REQ-043 Sustained contention: both valid for 6 cycles, out_ready 1 -> grants alternate 0,1,0,1,0,1; 6 results on consecutive cycles.
REQ-044 Backpressure: FULL holding 8'hF0, out_ready 0 for 3 cycles with req1 valid -> out_data stays 8'hF0, req1_ready 0; when out_ready = 1, the result is consumed and req1 is accepted in the same cycle.
REQ-045 Boundaries: amt 0 on 8'h5A -> 8'h5A; 8'hFF amt 7 dir 1 -> 8'h80; 8'hFF amt 7 dir 0 -> 8'h01.
REQ-046 Reset mid-operation: FULL with out_ready 0, rst pulsed 1 cycle -> out_valid 0, out_data 0, readies 0 during reset; next tie grants req0.
